// File: rtl/control_unit_pkg.sv
// control_unit_pkg
// Shared encodings for the multicycle control unit and the datapath ALU:
// FSM state enum, opcode constants, internal alu_op encoding, ALU operation
// codes and the per-state control bundle.
// Build option: CONTROL_UNIT_ILLEGAL_TRAP_EN adds the StTrap state and the
// illegal flag to the control bundle.

package control_unit_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StBeq      = 4'd9,
        StJal      = 4'd10
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
        ,
        StTrap     = 4'd11
`endif
    } state_t;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    typedef enum logic [1:0] {
        AluOpAdd   = 2'b00,
        AluOpSub   = 2'b01,
        AluOpFunct = 2'b10
    } alu_op_t;

    localparam logic [2:0] AluCtrlAdd = 3'b000;
    localparam logic [2:0] AluCtrlSub = 3'b001;
    localparam logic [2:0] AluCtrlAnd = 3'b010;
    localparam logic [2:0] AluCtrlOr  = 3'b011;
    localparam logic [2:0] AluCtrlSlt = 3'b101;

    // Per-state Moore outputs; pc_write and alu_control are derived from it.
    typedef struct packed {
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       pc_update;
        logic       branch;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        alu_op_t    alu_op;
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
        logic       illegal;
`endif
    } ctrl_t;

endpackage

// File: rtl/control_unit_alu_decoder.sv
// alu_decoder
// Maps the FSM's alu_op plus instruction funct fields onto the ALU operation.
// Ports:
//   i_alu_op      - 00 add, 01 sub, 10 decode funct fields
//   i_funct3      - instruction funct3
//   i_op5         - opcode bit 5 (1 for R-type, 0 for I-type)
//   i_funct7b5    - instruction bit 30
//   o_alu_control - ALU operation code

module alu_decoder
    import control_unit_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_op5,
    input  logic       i_funct7b5,
    output logic [2:0] o_alu_control
);

    always_comb begin
        o_alu_control = AluCtrlAdd;
        case (i_alu_op)
            AluOpAdd: o_alu_control = AluCtrlAdd;
            AluOpSub: o_alu_control = AluCtrlSub;
            AluOpFunct: begin
                case (i_funct3)
                    // Only R-type may subtract; addi with bit 30 set stays add.
                    3'b000:  o_alu_control = (i_op5 && i_funct7b5) ? AluCtrlSub : AluCtrlAdd;
                    3'b010:  o_alu_control = AluCtrlSlt;
                    3'b110:  o_alu_control = AluCtrlOr;
                    3'b111:  o_alu_control = AluCtrlAnd;
                    default: o_alu_control = AluCtrlAdd;
                endcase
            end
            default: o_alu_control = AluCtrlAdd;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// control_unit
// Moore FSM sequencing a multicycle RISC-V datapath (lw, sw, R-type, I-type
// ALU, beq, jal).
// Ports:
//   clk, rst_n               - clock (rising edge), async active-low reset
//   op, funct3, funct7b5     - instruction fields
//   zero                     - ALU zero flag, used by beq
//   pc_write, adr_src, mem_write, ir_write, reg_write,
//   result_src, alu_src_a, alu_src_b, alu_control - datapath controls
//   illegal_instr            - sticky illegal-opcode flag
// Build option: CONTROL_UNIT_ILLEGAL_TRAP_EN sends unknown opcodes to a trap
// state that holds until reset; without it they fall back to fetch.

module control_unit
    import control_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic       illegal_instr
);

    state_t     r_state;
    state_t     w_state_next;
    ctrl_t      w_ctrl;
    logic [2:0] w_alu_control;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = StFetch;
        case (r_state)
            StFetch: w_state_next = StDecode;
            StDecode: begin
                case (op)
                    OpLoad, OpStore: w_state_next = StMemAdr;
                    OpRType:         w_state_next = StExecR;
                    OpIType:         w_state_next = StExecI;
                    OpBranch:        w_state_next = StBeq;
                    OpJal:           w_state_next = StJal;
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
                    default:         w_state_next = StTrap;
`else
                    default:         w_state_next = StFetch;
`endif
                endcase
            end
            StMemAdr:   w_state_next = (op == OpLoad) ? StMemRead : StMemWrite;
            StMemRead:  w_state_next = StMemWb;
            StMemWb:    w_state_next = StFetch;
            StMemWrite: w_state_next = StFetch;
            StExecR:    w_state_next = StAluWb;
            StExecI:    w_state_next = StAluWb;
            StAluWb:    w_state_next = StFetch;
            StBeq:      w_state_next = StFetch;
            StJal:      w_state_next = StAluWb;
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
            StTrap:     w_state_next = StTrap;
`endif
            default:    w_state_next = StFetch;
        endcase
    end

    always_comb begin
        w_ctrl = '0;
        case (r_state)
            StFetch: begin
                w_ctrl.ir_write   = 1'b1;
                w_ctrl.pc_update  = 1'b1;
                w_ctrl.alu_src_b  = 2'b10;
                w_ctrl.result_src = 2'b10;
            end
            StDecode: begin
                w_ctrl.alu_src_a = 2'b01;
                w_ctrl.alu_src_b = 2'b01;
            end
            StMemAdr: begin
                w_ctrl.alu_src_a = 2'b10;
                w_ctrl.alu_src_b = 2'b01;
            end
            StMemRead: w_ctrl.adr_src = 1'b1;
            StMemWb: begin
                w_ctrl.result_src = 2'b01;
                w_ctrl.reg_write  = 1'b1;
            end
            StMemWrite: begin
                w_ctrl.adr_src   = 1'b1;
                w_ctrl.mem_write = 1'b1;
            end
            StExecR: begin
                w_ctrl.alu_src_a = 2'b10;
                w_ctrl.alu_op    = AluOpFunct;
            end
            StExecI: begin
                w_ctrl.alu_src_a = 2'b10;
                w_ctrl.alu_src_b = 2'b01;
                w_ctrl.alu_op    = AluOpFunct;
            end
            StAluWb: w_ctrl.reg_write = 1'b1;
            StBeq: begin
                w_ctrl.alu_src_a = 2'b10;
                w_ctrl.alu_op    = AluOpSub;
                w_ctrl.branch    = 1'b1;
            end
            StJal: begin
                w_ctrl.alu_src_a = 2'b01;
                w_ctrl.alu_src_b = 2'b10;
                w_ctrl.pc_update = 1'b1;
            end
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
            StTrap: w_ctrl.illegal = 1'b1;
`endif
            default: w_ctrl = '0;
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_alu_op      (w_ctrl.alu_op),
        .i_funct3      (funct3),
        .i_op5         (op[5]),
        .i_funct7b5    (funct7b5),
        .o_alu_control (w_alu_control)
    );

    // Outputs are forced low while reset is held, even though the state
    // register already sits in StFetch, so no enable leaks out during reset.
    assign pc_write    = rst_n & (w_ctrl.pc_update | (w_ctrl.branch & zero));
    assign adr_src     = rst_n & w_ctrl.adr_src;
    assign mem_write   = rst_n & w_ctrl.mem_write;
    assign ir_write    = rst_n & w_ctrl.ir_write;
    assign reg_write   = rst_n & w_ctrl.reg_write;
    assign result_src  = rst_n ? w_ctrl.result_src : 2'b00;
    assign alu_src_a   = rst_n ? w_ctrl.alu_src_a : 2'b00;
    assign alu_src_b   = rst_n ? w_ctrl.alu_src_b : 2'b00;
    assign alu_control = rst_n ? w_alu_control : 3'b000;
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
    assign illegal_instr = rst_n & w_ctrl.illegal;
`else
    assign illegal_instr = 1'b0;
`endif

endmodule
